// File: rtl/soc_region_map_pkg.sv
// Shared types, register offsets and helpers for the runtime-programmable SoC region map.
package soc_region_map_pkg;

    localparam int unsigned MaxAddrWidth = 64;
    localparam int unsigned MaxTgtW      = 8;
    localparam int unsigned MaxRules     = 64;

    localparam int OffBase    = 0;
    localparam int OffLen     = 1;
    localparam int OffCtrl    = 2;
    localparam int CtrlTgtLsb = 8;

    typedef struct packed {
        logic [MaxAddrWidth-1:0] base;
        logic [MaxAddrWidth-1:0] length;
        logic [MaxTgtW-1:0]      target;
        logic                    valid;
    } rule_t;

    typedef enum logic [1:0] {
        RspIdle,
        RspRead,
        RspWrite,
        RspErr
    } rsp_state_e;

    // The subtraction wraps at aw bits, so addresses below base never match.
    function automatic logic rule_match(input logic [MaxAddrWidth-1:0] addr,
                                        input rule_t                   rule,
                                        input int unsigned             aw);
        logic [MaxAddrWidth-1:0] mask;
        logic [MaxAddrWidth-1:0] diff;
        mask = {MaxAddrWidth{1'b1}} >> (MaxAddrWidth - aw);
        diff = (addr - rule.base) & mask;
        return rule.valid && (diff < rule.length);
    endfunction

    function automatic logic [MaxRules-1:0][MaxTgtW-1:0] identity_targets();
        logic [MaxRules-1:0][MaxTgtW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(MaxRules); i++) begin
            r[i] = MaxTgtW'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/soc_region_prio_match.sv
// Priority encoder over the per-rule match vector; the lowest set index wins.
module soc_region_prio_match #(
    parameter int unsigned NumRules = 11,
    parameter int unsigned RuleW    = 4
) (
    input  logic [NumRules-1:0] match,
    output logic                hit,
    output logic [RuleW-1:0]    idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = int'(NumRules) - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit = 1'b1;
                idx = RuleW'(i);
            end
        end
    end

endmodule

// File: rtl/soc_region_map.sv
// Programmable address region table with a one-cycle lookup pipeline, lock and decode-error counter.
module soc_region_map
    import soc_region_map_pkg::*;
#(
    parameter int unsigned NumRules   = 11,
    parameter int unsigned NumTargets = 11,
    parameter int unsigned AddrWidth  = 64,
    parameter logic [NumRules-1:0][AddrWidth-1:0] DefaultBase   = '0,
    parameter logic [NumRules-1:0][AddrWidth-1:0] DefaultLength = '0,
    parameter logic [NumRules-1:0][MaxTgtW-1:0]   DefaultTarget = (NumRules*MaxTgtW)'(identity_targets()),
    parameter logic [NumRules-1:0]                DefaultValid  = '1,
    localparam int unsigned TgtW  = (NumTargets > 1) ? $clog2(NumTargets) : 1,
    localparam int unsigned RuleW = (NumRules > 1) ? $clog2(NumRules) : 1,
    localparam int unsigned CfgAW = $clog2(3*NumRules+2)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [CfgAW-1:0]     cfg_addr_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_gnt_o,
    output logic                 cfg_rvalid_o,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic                 lookup_valid_i,
    input  logic [AddrWidth-1:0] lookup_addr_i,
    output logic                 lookup_valid_o,
    output logic                 lookup_hit_o,
    output logic [RuleW-1:0]     lookup_rule_o,
    output logic [TgtW-1:0]      lookup_target_o,
    output logic                 locked_o
);

    rule_t          rules_q [NumRules];
    logic           lock_q;
    logic [31:0]    errcnt_q;

    int             cfg_word;
    logic           dec_rule;
    logic           dec_lock;
    logic           dec_cnt;
    logic           dec_oor;
    int             dec_idx;
    int             dec_k;
    logic [AddrWidth-1:0] rd_data;

    logic           rule_wr;
    logic           lock_set;
    logic           cnt_clr;

    rsp_state_e     rsp_q;
    rsp_state_e     rsp_d;
    logic [AddrWidth-1:0] rdata_q;
    logic [AddrWidth-1:0] rdata_d;

    logic [NumRules-1:0] match;
    logic           hit_p0;
    logic [RuleW-1:0] rule_p0;
    logic [TgtW-1:0]  tgt_p0;

    logic           vld_p1;
    logic           hit_p1;
    logic [RuleW-1:0] rule_p1;
    logic [TgtW-1:0]  tgt_p1;

    assign cfg_word = int'(cfg_addr_i);

    always_comb begin
        dec_rule = 1'b0;
        dec_lock = 1'b0;
        dec_cnt  = 1'b0;
        dec_oor  = 1'b1;
        dec_idx  = 0;
        dec_k    = 0;
        for (int i = 0; i < int'(NumRules); i++) begin
            for (int k = 0; k < 3; k++) begin
                if (cfg_word == 3*i + k) begin
                    dec_rule = 1'b1;
                    dec_oor  = 1'b0;
                    dec_idx  = i;
                    dec_k    = k;
                end
            end
        end
        if (cfg_word == 3*int'(NumRules)) begin
            dec_lock = 1'b1;
            dec_oor  = 1'b0;
        end
        if (cfg_word == 3*int'(NumRules) + 1) begin
            dec_cnt = 1'b1;
            dec_oor = 1'b0;
        end
    end

    assign rule_wr  = cfg_req_i && cfg_we_i && dec_rule && !lock_q;
    assign lock_set = cfg_req_i && cfg_we_i && dec_lock && cfg_wdata_i[0];
    assign cnt_clr  = cfg_req_i && cfg_we_i && dec_cnt;

    always_comb begin
        rd_data = '0;
        if (dec_rule) begin
            for (int i = 0; i < int'(NumRules); i++) begin
                if (i == dec_idx) begin
                    case (dec_k)
                        OffBase: rd_data = AddrWidth'(rules_q[i].base);
                        OffLen:  rd_data = AddrWidth'(rules_q[i].length);
                        default: begin
                            rd_data[0] = rules_q[i].valid;
                            rd_data[CtrlTgtLsb +: MaxTgtW] = rules_q[i].target;
                        end
                    endcase
                end
            end
        end else if (dec_lock) begin
            rd_data[0] = lock_q;
        end else if (dec_cnt) begin
            rd_data[31:0] = errcnt_q;
        end
    end

    // Response FSM: the state remembers what kind of answer is owed next cycle.
    always_comb begin
        rsp_d   = RspIdle;
        rdata_d = '0;
        if (cfg_req_i) begin
            if (dec_oor) begin
                rsp_d = RspErr;
            end else if (cfg_we_i) begin
                rsp_d = (dec_rule && lock_q) ? RspErr : RspWrite;
            end else begin
                rsp_d   = RspRead;
                rdata_d = rd_data;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_q   <= RspIdle;
            rdata_q <= '0;
        end else begin
            rsp_q   <= rsp_d;
            rdata_q <= rdata_d;
        end
    end

    assign cfg_gnt_o    = cfg_req_i;
    assign cfg_rvalid_o = (rsp_q != RspIdle);
    assign cfg_err_o    = (rsp_q == RspErr);
    assign cfg_rdata_o  = rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumRules); i++) begin
                rules_q[i].base   <= MaxAddrWidth'(DefaultBase[i]);
                rules_q[i].length <= MaxAddrWidth'(DefaultLength[i]);
                rules_q[i].target <= MaxTgtW'(DefaultTarget[i][TgtW-1:0]);
                rules_q[i].valid  <= DefaultValid[i];
            end
            lock_q <= 1'b0;
        end else begin
            if (rule_wr) begin
                for (int i = 0; i < int'(NumRules); i++) begin
                    if (i == dec_idx) begin
                        case (dec_k)
                            OffBase: rules_q[i].base   <= MaxAddrWidth'(cfg_wdata_i);
                            OffLen:  rules_q[i].length <= MaxAddrWidth'(cfg_wdata_i);
                            default: begin
                                rules_q[i].valid  <= cfg_wdata_i[0];
                                rules_q[i].target <= MaxTgtW'(cfg_wdata_i[CtrlTgtLsb +: TgtW]);
                            end
                        endcase
                    end
                end
            end
            if (lock_set) begin
                lock_q <= 1'b1;
            end
        end
    end

    // Stage p0: match against the table as it stands before any write this cycle.
    always_comb begin
        for (int i = 0; i < int'(NumRules); i++) begin
            match[i] = rule_match(MaxAddrWidth'(lookup_addr_i), rules_q[i], AddrWidth);
        end
    end

    soc_region_prio_match #(
        .NumRules (NumRules),
        .RuleW    (RuleW)
    ) u_prio (
        .match (match),
        .hit   (hit_p0),
        .idx   (rule_p0)
    );

    always_comb begin
        tgt_p0 = '0;
        for (int i = 0; i < int'(NumRules); i++) begin
            if (hit_p0 && (rule_p0 == RuleW'(i))) begin
                tgt_p0 = rules_q[i].target[TgtW-1:0];
            end
        end
    end

    // Stage p1: registered lookup result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1  <= 1'b0;
            hit_p1  <= 1'b0;
            rule_p1 <= '0;
            tgt_p1  <= '0;
        end else begin
            vld_p1  <= lookup_valid_i;
            hit_p1  <= lookup_valid_i && hit_p0;
            rule_p1 <= (lookup_valid_i && hit_p0) ? rule_p0 : '0;
            tgt_p1  <= (lookup_valid_i && hit_p0) ? tgt_p0 : '0;
        end
    end

    // Clear has priority over a same-cycle miss.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            errcnt_q <= '0;
        end else if (cnt_clr) begin
            errcnt_q <= '0;
        end else if (lookup_valid_i && !hit_p0 && (errcnt_q != '1)) begin
            errcnt_q <= errcnt_q + 32'd1;
        end
    end

    assign lookup_valid_o  = vld_p1;
    assign lookup_hit_o    = hit_p1;
    assign lookup_rule_o   = rule_p1;
    assign lookup_target_o = tgt_p1;
    assign locked_o        = lock_q;

endmodule

// File: tb/tb_soc_region_map.sv
// Bench for soc_region_map: directed scenarios plus random traffic against a behavioural table model.
module tb_soc_region_map;

    localparam int NR       = 11;
    localparam int TW       = 4;
    localparam int RW       = 4;
    localparam int CAW      = 6;
    localparam int LOCK_IDX = 3*NR;
    localparam int CNT_IDX  = 3*NR + 1;
    localparam logic [NR-1:0][63:0] DEF_BASE = (NR*64)'(64'h8000_0000);
    localparam logic [NR-1:0][63:0] DEF_LEN  = (NR*64)'(64'h4000_0000);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_req = 1'b0;
    logic            cfg_we = 1'b0;
    logic [CAW-1:0]  cfg_addr = '0;
    logic [63:0]     cfg_wdata = '0;
    logic            lookup_valid = 1'b0;
    logic [63:0]     lookup_addr = '0;

    logic            cfg_gnt_o;
    logic            cfg_rvalid_o;
    logic [63:0]     cfg_rdata_o;
    logic            cfg_err_o;
    logic            lookup_valid_o;
    logic            lookup_hit_o;
    logic [RW-1:0]   lookup_rule_o;
    logic [TW-1:0]   lookup_target_o;
    logic            locked_o;

    int vectors = 0;
    int miscompares = 0;

    soc_region_map #(
        .NumRules      (NR),
        .NumTargets    (11),
        .AddrWidth     (64),
        .DefaultBase   (DEF_BASE),
        .DefaultLength (DEF_LEN)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .cfg_req_i       (cfg_req),
        .cfg_we_i        (cfg_we),
        .cfg_addr_i      (cfg_addr),
        .cfg_wdata_i     (cfg_wdata),
        .cfg_gnt_o       (cfg_gnt_o),
        .cfg_rvalid_o    (cfg_rvalid_o),
        .cfg_rdata_o     (cfg_rdata_o),
        .cfg_err_o       (cfg_err_o),
        .lookup_valid_i  (lookup_valid),
        .lookup_addr_i   (lookup_addr),
        .lookup_valid_o  (lookup_valid_o),
        .lookup_hit_o    (lookup_hit_o),
        .lookup_rule_o   (lookup_rule_o),
        .lookup_target_o (lookup_target_o),
        .locked_o        (locked_o)
    );

    always #5 clk = ~clk;

    // Behavioural model state and the outputs it predicts for the current cycle.
    logic [63:0] m_base [NR];
    logic [63:0] m_len  [NR];
    int          m_tgt  [NR];
    bit          m_valid[NR];
    bit          m_lock;
    logic [31:0] m_cnt;
    bit          sat_load = 1'b0;

    bit          e_vld, e_hit, e_rvalid, e_err;
    int          e_rule, e_tgt;
    logic [63:0] e_rdata;

    int          mf, midx, mi, mk;
    bit          mclr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_find(input logic [63:0] a);
        for (int i = 0; i < NR; i++) begin
            if (m_valid[i] && ((a - m_base[i]) < m_len[i])) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_base[i]  = 64'h0;
            m_len[i]   = 64'h0;
            m_tgt[i]   = i;
            m_valid[i] = 1'b1;
        end
        m_base[0] = 64'h8000_0000;
        m_len[0]  = 64'h4000_0000;
        m_lock    = 1'b0;
        m_cnt     = 32'h0;
        e_vld = 0; e_hit = 0; e_rule = 0; e_tgt = 0;
        e_rvalid = 0; e_err = 0; e_rdata = 64'h0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            mf     = model_find(lookup_addr);
            e_vld  = lookup_valid;
            e_hit  = lookup_valid && (mf >= 0);
            e_rule = e_hit ? mf : 0;
            e_tgt  = e_hit ? m_tgt[mf] : 0;
            e_rvalid = cfg_req;
            e_err    = 1'b0;
            e_rdata  = 64'h0;
            mclr     = 1'b0;
            if (cfg_req) begin
                midx = int'(cfg_addr);
                if (midx < 3*NR) begin
                    mi = midx / 3;
                    mk = midx % 3;
                    if (cfg_we) begin
                        if (m_lock) e_err = 1'b1;
                        else if (mk == 0) m_base[mi] = cfg_wdata;
                        else if (mk == 1) m_len[mi] = cfg_wdata;
                        else begin
                            m_valid[mi] = cfg_wdata[0];
                            m_tgt[mi]   = int'((cfg_wdata >> 8) % 64'd16);
                        end
                    end else begin
                        if (mk == 0) e_rdata = m_base[mi];
                        else if (mk == 1) e_rdata = m_len[mi];
                        else e_rdata = 64'(m_tgt[mi]) * 64'd256 + 64'(m_valid[mi]);
                    end
                end else if (midx == LOCK_IDX) begin
                    if (cfg_we) begin
                        if (cfg_wdata[0]) m_lock = 1'b1;
                    end else e_rdata = 64'(m_lock);
                end else if (midx == CNT_IDX) begin
                    if (cfg_we) mclr = 1'b1;
                    else e_rdata = 64'(m_cnt);
                end else begin
                    e_err = 1'b1;
                end
            end
            if (sat_load) m_cnt = 32'hFFFF_FFFE;
            else if (mclr) m_cnt = 32'h0;
            else if (lookup_valid && (mf < 0) && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("lookup_valid", 64'(lookup_valid_o), 64'(e_vld));
            chk("lookup_hit", 64'(lookup_hit_o), 64'(e_hit));
            chk("lookup_rule", 64'(lookup_rule_o), 64'(e_rule));
            chk("lookup_target", 64'(lookup_target_o), 64'(e_tgt));
            chk("cfg_rvalid", 64'(cfg_rvalid_o), 64'(e_rvalid));
            chk("cfg_gnt", 64'(cfg_gnt_o), 64'(cfg_req));
            chk("locked", 64'(locked_o), 64'(m_lock));
            if (e_rvalid || !rst_n) begin
                chk("cfg_err", 64'(cfg_err_o), 64'(e_err));
                chk("cfg_rdata", cfg_rdata_o, e_rdata);
            end
        end
    end

    task automatic apply(input bit req, input bit we, input int addr, input logic [63:0] wd,
                         input bit lv, input logic [63:0] la);
        cfg_req      = req;
        cfg_we       = we;
        cfg_addr     = CAW'(addr);
        cfg_wdata    = wd;
        lookup_valid = lv;
        lookup_addr  = la;
        @(negedge clk);
    endtask

    task automatic wr(input int idx, input logic [63:0] d);
        apply(1, 1, idx, d, 0, 64'h0);
    endtask

    task automatic rd(input int idx);
        apply(1, 0, idx, 64'h0, 0, 64'h0);
    endtask

    task automatic lk(input logic [63:0] a);
        apply(0, 0, 0, 64'h0, 1, a);
    endtask

    task automatic idle();
        apply(0, 0, 0, 64'h0, 0, 64'h0);
    endtask

    logic [63:0] rwd;
    logic [63:0] rla;
    int          ridx;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("reset lookup_valid", 64'(lookup_valid_o), 64'h0);
        chk("reset locked", 64'(locked_o), 64'h0);
        chk("reset rvalid", 64'(cfg_rvalid_o), 64'h0);

        lk(64'h8000_1000);
        chk("dram valid", 64'(lookup_valid_o), 64'h1);
        chk("dram hit", 64'(lookup_hit_o), 64'h1);
        chk("dram rule", 64'(lookup_rule_o), 64'h0);
        lk(64'hC000_0000);
        chk("dram end miss", 64'(lookup_hit_o), 64'h0);
        rd(CNT_IDX);
        chk("errcnt one", cfg_rdata_o, 64'h1);

        wr(27, 64'h1900_0000); wr(28, 64'h1000); wr(29, 64'h0901);
        lk(64'h1900_0FFF);
        chk("r9 hit", 64'(lookup_hit_o), 64'h1);
        chk("r9 rule", 64'(lookup_rule_o), 64'h9);
        chk("r9 target", 64'(lookup_target_o), 64'h9);
        lk(64'h1900_1000);
        chk("r9 end miss", 64'(lookup_hit_o), 64'h0);

        wr(6, 64'h3000_0000); wr(7, 64'h1000); wr(8, 64'h0201);
        wr(15, 64'h3000_0000); wr(16, 64'h1_0000); wr(17, 64'h0501);
        lk(64'h3000_0000);
        chk("overlap rule", 64'(lookup_rule_o), 64'h2);
        wr(8, 64'h0200);
        lk(64'h3000_0000);
        chk("overlap fallback rule", 64'(lookup_rule_o), 64'h5);
        chk("overlap fallback target", 64'(lookup_target_o), 64'h5);

        apply(1, 1, 15, 64'h4000_0000, 1, 64'h3000_0010);
        chk("same-cycle old base", 64'(lookup_hit_o), 64'h1);
        lk(64'h3000_0010);
        chk("next-cycle new base", 64'(lookup_hit_o), 64'h0);
        lk(64'h4000_0010);
        chk("moved rule", 64'(lookup_rule_o), 64'h5);

        wr(9, 64'hFFFF_FFFF_FFFF_F000); wr(10, 64'h1000); wr(11, 64'h0301);
        lk(64'hFFFF_FFFF_FFFF_FFFF);
        chk("top hit", 64'(lookup_hit_o), 64'h1);
        chk("top rule", 64'(lookup_rule_o), 64'h3);
        lk(64'h0);
        chk("zero miss", 64'(lookup_hit_o), 64'h0);
        wr(12, 64'h10);
        lk(64'h10);
        chk("len0 miss", 64'(lookup_hit_o), 64'h0);

        rd(35);
        chk("oor read err", 64'(cfg_err_o), 64'h1);
        wr(63, 64'hDEAD);
        chk("oor write err", 64'(cfg_err_o), 64'h1);

        force dut.errcnt_q = 32'hFFFF_FFFE;
        sat_load = 1'b1;
        @(posedge clk);
        #1;
        release dut.errcnt_q;
        sat_load = 1'b0;
        @(negedge clk);
        lk(64'hC000_0000);
        lk(64'hC000_0000);
        rd(CNT_IDX);
        chk("errcnt saturate", cfg_rdata_o, 64'hFFFF_FFFF);
        apply(1, 1, CNT_IDX, 64'h0, 1, 64'hC000_0000);
        rd(CNT_IDX);
        chk("clear beats miss", cfg_rdata_o, 64'h0);

        for (int n = 0; n < 600; n++) begin
            ridx = $urandom_range(0, 37);
            if (ridx < 3*NR && ridx % 3 == 0) rwd = 64'($urandom_range(0, 7)) << 28;
            else if (ridx < 3*NR && ridx % 3 == 1) rwd = 64'($urandom_range(0, 4)) << 26;
            else rwd = {$urandom, $urandom};
            if (ridx == LOCK_IDX) rwd[0] = 1'b0;
            if ($urandom_range(0, 3) == 0) rla = {$urandom, $urandom};
            else rla = (64'($urandom_range(0, 7)) << 28) + 64'($urandom_range(0, 32'h0FFF_FFFF));
            apply($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ridx, rwd,
                  $urandom_range(0, 2) != 0, rla);
        end

        wr(0, 64'h8000_0000);
        wr(LOCK_IDX, 64'h0);
        chk("lock0 no err", 64'(cfg_err_o), 64'h0);
        chk("lock0 unlocked", 64'(locked_o), 64'h0);
        wr(LOCK_IDX, 64'h1);
        chk("lock set", 64'(locked_o), 64'h1);
        wr(0, 64'h1234);
        chk("locked write err", 64'(cfg_err_o), 64'h1);
        rd(0);
        chk("locked readback", cfg_rdata_o, 64'h8000_0000);
        wr(CNT_IDX, 64'h0);
        chk("locked clear no err", 64'(cfg_err_o), 64'h0);
        rd(CNT_IDX);
        chk("locked clear value", cfg_rdata_o, 64'h0);

        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = CAW'(0);
        lookup_valid = 1'b1; lookup_addr = 64'h8000_1000;
        #2 rst_n = 1'b0;
        @(negedge clk);
        cfg_req = 1'b0; lookup_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("post-reset no valid", 64'(lookup_valid_o), 64'h0);
        chk("post-reset no rvalid", 64'(cfg_rvalid_o), 64'h0);
        chk("post-reset unlocked", 64'(locked_o), 64'h0);
        lk(64'h8000_1000);
        chk("post-reset default hit", 64'(lookup_hit_o), 64'h1);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/soc_region_map.md
Name: soc_region_map

Overview:
- Runtime-programmable successor to the static SoC address map.
- Holds NumRules address regions (base, length, target index, valid), each reset-initialised from parameters.
- Rules are reprogrammable through a simple req/gnt register port, and the whole table can be locked until the next reset.
- Sits in front of the crossbar decode and serves a one-cycle pipelined lookup port. It also counts decode errors (lookups that match no rule).

Parameters:
- NumRules, 11, number of region rules (1..64).
- NumTargets, 11, number of crossbar targets; target field width TgtW = max(1, $clog2(NumTargets)).
- AddrWidth, 64, address and register data width.
- DefaultBase, all-zero array [NumRules], reset base per rule.
- DefaultLength, all-zero array [NumRules], reset length per rule.
- DefaultTarget, identity array [NumRules], reset target per rule.
- DefaultValid, all-ones [NumRules], reset valid bit per rule.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- cfg_req_i  in  1  register access request
- cfg_we_i  in  1  1 = write, 0 = read
- cfg_addr_i  in  $clog2(3*NumRules+2)  register word index
- cfg_wdata_i  in  AddrWidth  write data
- cfg_gnt_o  out  1  grant
- cfg_rvalid_o  out  1  response valid, one cycle after grant
- cfg_rdata_o  out  AddrWidth  read data
- cfg_err_o  out  1  response error, qualified by cfg_rvalid_o
- lookup_valid_i  in  1  lookup request
- lookup_addr_i  in  AddrWidth  address to decode
- lookup_valid_o  out  1  result valid
- lookup_hit_o  out  1  some rule matched
- lookup_rule_o  out  $clog2(NumRules)  matching rule index
- lookup_target_o  out  TgtW  target of the matching rule
- locked_o  out  1  table locked

Behaviour:
- Reset: rule registers take their Default* values; lock=0; error counter=0. All outputs are 0 during and right after reset.
- Register map, index r = 3*i + k for rule i:
  - k=0: BASE.
  - k=1: LENGTH.
  - k=2: CTRL, bit0 = valid, bits[8 +: TgtW] = target. Other CTRL bits are written as don't-care and read as 0.
  - Index 3*NumRules: LOCK, bit0.
  - Index 3*NumRules+1: ERRCNT, 32-bit, zero-extended on read.
- cfg_gnt_o = cfg_req_i combinationally; every request is granted in the same cycle.
- Response timing: cfg_rvalid_o is asserted exactly one cycle after grant. cfg_rdata_o is valid for reads and 0 for writes.
- Writes:
  - Write to a rule register while locked: no update, cfg_err_o=1.
  - Write LOCK with bit0=1: sets the lock; only reset clears it. Writing 0 has no effect and no error.
  - Write ERRCNT with any data: clears the counter, even while locked.
  - Index beyond ERRCNT: cfg_err_o=1, rdata=0, no state change.
  - Reads never error except for an out-of-range index.
- Match rule for i: valid_i and (addr - base_i) < length_i, evaluated as an unsigned AddrWidth-bit subtraction. addr < base wraps to a large value, so there is no overflow issue.
  - length 0 never matches.
  - base+length may reach the top of the address space; the subtraction handles it correctly.
- Priority: the lowest matching index wins; overlapping rules are legal.
- Lookup latency: 1 cycle, fully pipelined, no backpressure.
  - lookup_valid_o <= lookup_valid_i.
  - hit/rule/target are registered on the same edge.
  - On a miss, rule and target are 0 and hit is 0.
- Simultaneous cfg write and lookup in the same cycle: the lookup uses the pre-write table. The write is visible to a lookup issued the next cycle.
- ERRCNT:
  - Increments by 1 on each accepted lookup miss (lookup_valid_i with no hit), counted at the result edge.
  - Saturates at 2^32-1.
  - Clear and increment in the same cycle: clear wins, so the value becomes 0.
- locked_o mirrors the lock register.
- Asynchronous reset mid-operation: in-flight lookup and cfg responses are dropped, so no rvalid/valid pulse follows reset deassertion.

Decomposition:
- Package soc_region_map_pkg holds:
  - rule_t struct {base, length, target, valid};
  - register offset constants (OffBase=0, OffLen=1, OffCtrl=2);
  - function rule_match(addr, rule_t) returning the match bit.
- ariane_soc supplies the Default* arrays built from its existing Base/Length constants.
- One sub-module, soc_region_prio_match: combinational NumRules-wide match vector to priority-encoded index/hit (leading-zero from LSB). The top level holds the registers, cfg FSM, pipeline and counter.

Test Plan:
- Reset with the default map (DRAM rule base 0x8000_0000, length 0x4000_0000, target 0). Lookup 0x8000_1000 -> next cycle valid=1, hit=1, rule=0, target=0. Lookup 0xC000_0000 -> hit=0, ERRCNT reads 1.
- Program rule 9: write BASE=0x1900_0000, LENGTH=0x1000, CTRL=0x0901. Lookups 0x1900_0FFF -> hit, target 9; 0x1900_1000 -> miss.
- Overlap: rules 2 and 5 both cover 0x3000_0000 -> rule_o=2. Clear rule 2 valid -> next lookup gives rule_o=5.
- Same-cycle write BASE and lookup on the affected rule -> result reflects the old base; the lookup on the following cycle reflects the new base.
- Write LOCK=1, then write BASE of rule 0 -> cfg_err_o=1, readback unchanged, locked_o=1. ERRCNT clear is still accepted.
- Edge cases:
  - Rule base 0xFFFF_FFFF_FFFF_F000, length 0x1000: address 0xFFFF_FFFF_FFFF_FFFF hits, address 0 misses.
  - Length 0 never hits.
  - Force ERRCNT to saturation and issue one more miss -> it holds 0xFFFF_FFFF.
  - Out-of-range cfg index -> cfg_err_o=1.
